// File: rtl/phold_scheduler_if.sv
// Bundle of the scheduler's queue, core and output-stream signals.
// master: the scheduler itself; slave: the surrounding system (queue, cores, sink).
interface phold_scheduler_if #(
    parameter int NCORE = 4,
    parameter int NIDB  = 3,
    parameter int NRB   = 8
);
    logic                    q_valid;
    logic [15:0]             q_time;
    logic [NIDB-1:0]         q_id;
    logic                    q_pop;
    logic [NCORE-1:0]        core_event_valid;
    logic [15:0]             core_event_time;
    logic [NIDB-1:0]         core_event_id;
    logic [NRB-1:0]          core_random;
    logic [NCORE-1:0]        core_new_valid;
    logic [16*NCORE-1:0]     core_new_time;
    logic [NIDB*NCORE-1:0]   core_new_target;
    logic                    out_valid;
    logic [15:0]             out_time;
    logic [NIDB-1:0]         out_id;
    logic                    out_ready;
    logic [15:0]             global_time;

    modport master (
        input  q_valid, q_time, q_id, core_new_valid, core_new_time, core_new_target, out_ready,
        output q_pop, core_event_valid, core_event_time, core_event_id, core_random,
               out_valid, out_time, out_id, global_time
    );

    modport slave (
        output q_valid, q_time, q_id, core_new_valid, core_new_time, core_new_target, out_ready,
        input  q_pop, core_event_valid, core_event_time, core_event_id, core_random,
               out_valid, out_time, out_id, global_time
    );
endinterface

// File: rtl/phold_scheduler.sv
// PHOLD core-bank scheduler: dispatches queue events to idle cores with an
// LFSR random number, collects generated events into per-core slots, drains
// them round-robin onto one valid/ready stream, and tracks GVT.
module phold_scheduler #(
    parameter int          NCORE = 4,
    parameter int          NIDB  = 3,
    parameter int          NRB   = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    phold_scheduler_if.master  bus
);
    localparam int IW = (NCORE > 1) ? $clog2(NCORE) : 1;

    logic [NCORE-1:0]            busy, pend;
    logic [NCORE-1:0][15:0]      dtime, htime;
    logic [NCORE-1:0][NIDB-1:0]  hid;
    logic [15:0]                 lfsr, lfsr_nxt;
    logic [IW-1:0]               rr_ptr, rr_nxt, owner, disp_idx, gnt_idx, scan_idx;
    logic                        has_free, gnt_found, load, accept, gvt_any;
    logic [15:0]                 gvt_min;

    // Galois step for x^16+x^14+x^13+x^11+1 (right-shifting form)
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Lowest-index idle core is the dispatch target
    always_comb begin
        has_free = 1'b0;
        disp_idx = '0;
        for (int i = NCORE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                has_free = 1'b1;
                disp_idx = IW'(i);
            end
        end
    end

    // Gated by reset so nothing is consumed while the bank is held in reset
    assign bus.q_pop = rst_n & bus.q_valid & has_free;

    // Round-robin grant: first pending slot at or above rr_ptr, wrapping
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int o = NCORE - 1; o >= 0; o--) begin
            scan_idx = (int'(rr_ptr) + o >= NCORE) ? IW'(int'(rr_ptr) + o - NCORE)
                                                    : IW'(int'(rr_ptr) + o);
            if (pend[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign accept = bus.out_valid & bus.out_ready;
    assign load   = (~bus.out_valid | bus.out_ready) & gnt_found;
    assign rr_nxt = (gnt_idx == IW'(NCORE - 1)) ? '0 : gnt_idx + 1'b1;

    // Minimum over queue head and every outstanding dispatched timestamp
    always_comb begin
        gvt_any = bus.q_valid;
        gvt_min = bus.q_time;
        for (int i = 0; i < NCORE; i++) begin
            if (busy[i] && (!gvt_any || dtime[i] < gvt_min)) begin
                gvt_any = 1'b1;
                gvt_min = dtime[i];
            end
        end
    end

    // Dispatch register: one-cycle strobe to the chosen core plus broadcast payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.core_event_valid <= '0;
            bus.core_event_time  <= '0;
            bus.core_event_id    <= '0;
            bus.core_random      <= '0;
            lfsr                 <= SEED;
        end else begin
            bus.core_event_valid <= '0;
            if (bus.q_pop) begin
                bus.core_event_valid <= NCORE'(1) << disp_idx;
                bus.core_event_time  <= bus.q_time;
                bus.core_event_id    <= bus.q_id;
                bus.core_random      <= lfsr[NRB-1:0];
                lfsr                 <= lfsr_nxt;
            end
        end
    end

    // Busy tracking: set on dispatch, cleared when the core's event is accepted downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            dtime <= '0;
        end else begin
            if (accept) busy[owner] <= 1'b0;
            if (bus.q_pop) begin
                busy[disp_idx]  <= 1'b1;
                dtime[disp_idx] <= bus.q_time;
            end
        end
    end

    // Holding slots: capture legal new-event pulses, free the slot that is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend  <= '0;
            htime <= '0;
            hid   <= '0;
        end else begin
            if (load) pend[gnt_idx] <= 1'b0;
            for (int i = 0; i < NCORE; i++) begin
                if (bus.core_new_valid[i] && busy[i] && !pend[i]) begin
                    pend[i]  <= 1'b1;
                    htime[i] <= bus.core_new_time[16*i +: 16];
                    hid[i]   <= bus.core_new_target[NIDB*i +: NIDB];
                end
            end
        end
    end

    // Output stage: holds its event until accepted, reloads in the same cycle when possible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_time  <= '0;
            bus.out_id    <= '0;
            owner         <= '0;
            rr_ptr        <= '0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_time  <= htime[gnt_idx];
            bus.out_id    <= hid[gnt_idx];
            owner         <= gnt_idx;
            rr_ptr        <= rr_nxt;
        end else if (accept) begin
            bus.out_valid <= 1'b0;
        end
    end

    // GVT register: holds its value when nothing is outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       bus.global_time <= '0;
        else if (gvt_any) bus.global_time <= gvt_min;
    end
endmodule

// File: tb/tb_phold_scheduler.sv
// Self-checking bench for phold_scheduler: directed scenarios plus a
// randomized run against a behavioural model of the scheduling rules.
module tb_phold_scheduler;
    localparam int          NCORE = 4;
    localparam int          NIDB  = 3;
    localparam int          NRB   = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    phold_scheduler_if #(.NCORE(NCORE), .NIDB(NIDB), .NRB(NRB)) bus ();

    phold_scheduler #(.NCORE(NCORE), .NIDB(NIDB), .NRB(NRB), .SEED(SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.q_valid = 1'b0; bus.q_time = '0; bus.q_id = '0;
        bus.core_new_valid = '0; bus.core_new_time = '0; bus.core_new_target = '0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic pulse(input int c, input logic [15:0] t, input logic [NIDB-1:0] id);
        bus.core_new_valid[c] = 1'b1;
        bus.core_new_time[16*c +: 16] = t;
        bus.core_new_target[NIDB*c +: NIDB] = id;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        bus.q_valid = 1'b1; bus.q_time = 16'h0010; bus.q_id = 3'd3; bus.out_ready = 1'b1;
        tick(); tick();
        checks++; if (bus.q_pop !== 1'b0) begin errors++; $display("FAIL reset_q_pop: got %b exp 0", bus.q_pop); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
        checks++; if (bus.global_time !== 16'h0) begin errors++; $display("FAIL reset_gvt: got %h exp 0", bus.global_time); end
        checks++; if (bus.core_event_valid !== 4'b0) begin errors++; $display("FAIL reset_cev: got %b exp 0000", bus.core_event_valid); end
        rst_n = 1'b1;
        #1;
        checks++; if (bus.q_pop !== 1'b1) begin errors++; $display("FAIL post_reset_q_pop: got %b exp 1", bus.q_pop); end
        tick();
        bus.q_valid = 1'b0;
        checks++; if (bus.core_event_valid !== 4'b0001) begin errors++; $display("FAIL first_dispatch_cev: got %b exp 0001", bus.core_event_valid); end
        checks++; if (bus.core_random !== 8'hE1) begin errors++; $display("FAIL first_random: got %h exp e1", bus.core_random); end
        checks++; if (bus.core_event_time !== 16'h0010 || bus.core_event_id !== 3'd3) begin errors++; $display("FAIL first_payload: got %h/%0d exp 0010/3", bus.core_event_time, bus.core_event_id); end
        checks++; if (bus.global_time !== 16'h0010) begin errors++; $display("FAIL first_gvt: got %h exp 0010", bus.global_time); end
    endtask

    task automatic test_fill();
        logic [15:0]      exp_l;
        logic [NCORE-1:0] exp_cev;
        do_reset();
        exp_l = SEED;
        bus.q_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.q_time = 16'h0100 + 16'(c);
            bus.q_id = NIDB'(c);
            #1;
            checks++; if (bus.q_pop !== (c < 4)) begin errors++; $display("FAIL fill_q_pop[%0d]: got %b exp %b", c, bus.q_pop, (c < 4)); end
            tick();
            exp_cev = (c < 4) ? (NCORE'(1) << c) : '0;
            checks++; if (bus.core_event_valid !== exp_cev) begin errors++; $display("FAIL fill_cev[%0d]: got %b exp %b", c, bus.core_event_valid, exp_cev); end
            if (c < 4) begin
                checks++; if (bus.core_random !== exp_l[NRB-1:0]) begin errors++; $display("FAIL fill_random[%0d]: got %h exp %h", c, bus.core_random, exp_l[NRB-1:0]); end
                exp_l = lfsr_step(exp_l);
            end
        end
        bus.q_valid = 1'b0;
    endtask

    task automatic test_collect_release();
        pulse(2, 16'h0030, 3'd5);
        tick();
        bus.core_new_valid = '0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL collect_early_valid: got %b exp 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_time !== 16'h0030 || bus.out_id !== 3'd5) begin errors++; $display("FAIL collect_out: got v%b %h/%0d exp v1 0030/5", bus.out_valid, bus.out_time, bus.out_id); end
        bus.out_ready = 1'b1; bus.q_valid = 1'b1; bus.q_time = 16'h0200; bus.q_id = 3'd6;
        #1;
        checks++; if (bus.q_pop !== 1'b0) begin errors++; $display("FAIL release_same_cycle_pop: got %b exp 0", bus.q_pop); end
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_drop: got %b exp 0", bus.out_valid); end
        #1;
        checks++; if (bus.q_pop !== 1'b1) begin errors++; $display("FAIL release_next_pop: got %b exp 1", bus.q_pop); end
        tick();
        bus.q_valid = 1'b0;
        checks++; if (bus.core_event_valid !== 4'b0100 || bus.core_event_time !== 16'h0200) begin errors++; $display("FAIL redispatch_core2: got %b %h exp 0100 0200", bus.core_event_valid, bus.core_event_time); end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.q_valid = 1'b1; bus.q_time = 16'h0010;
        repeat (4) tick();
        bus.q_valid = 1'b0;
        pulse(0, 16'h0011, 3'd1); pulse(1, 16'h0022, 3'd2); pulse(3, 16'h0033, 3'd3);
        tick();
        bus.core_new_valid = '0;
        tick();
        for (int s = 0; s < 3; s++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_time !== 16'h0011 || bus.out_id !== 3'd1) begin errors++; $display("FAIL rr_hold[%0d]: got v%b %h/%0d exp v1 0011/1", s, bus.out_valid, bus.out_time, bus.out_id); end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_time !== 16'h0022 || bus.out_id !== 3'd2) begin errors++; $display("FAIL rr_second: got v%b %h/%0d exp v1 0022/2", bus.out_valid, bus.out_time, bus.out_id); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_time !== 16'h0033 || bus.out_id !== 3'd3) begin errors++; $display("FAIL rr_third: got v%b %h/%0d exp v1 0033/3", bus.out_valid, bus.out_time, bus.out_id); end
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rr_drained: got %b exp 0", bus.out_valid); end
    endtask

    task automatic test_gvt();
        logic [15:0] t[4];
        t = '{16'h0050, 16'h0020, 16'h0060, 16'h0070};
        do_reset();
        bus.q_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.q_time = t[i];
            tick();
        end
        bus.q_time = 16'h0040;
        #1;
        checks++; if (bus.q_pop !== 1'b0) begin errors++; $display("FAIL gvt_full_pop: got %b exp 0", bus.q_pop); end
        tick(); tick();
        checks++; if (bus.global_time !== 16'h0020) begin errors++; $display("FAIL gvt_min: got %h exp 0020", bus.global_time); end
        pulse(1, 16'h0099, 3'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.core_new_valid = '0;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_time !== 16'h0099) begin errors++; $display("FAIL gvt_out: got v%b %h exp v1 0099", bus.out_valid, bus.out_time); end
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.global_time !== 16'h0020) begin errors++; $display("FAIL gvt_release_edge: got %h exp 0020", bus.global_time); end
        #1;
        checks++; if (bus.q_pop !== 1'b1) begin errors++; $display("FAIL gvt_release_pop: got %b exp 1", bus.q_pop); end
        tick();
        bus.q_valid = 1'b0;
        checks++; if (bus.global_time !== 16'h0040) begin errors++; $display("FAIL gvt_after_release: got %h exp 0040", bus.global_time); end
        checks++; if (bus.core_event_valid !== 4'b0010) begin errors++; $display("FAIL gvt_redispatch: got %b exp 0010", bus.core_event_valid); end
    endtask

    task automatic test_spurious_async_reset();
        do_reset();
        pulse(1, 16'h0055, 3'd2);
        tick();
        bus.core_new_valid = '0;
        tick(); tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL spurious_ignored: got %b exp 0", bus.out_valid); end
        bus.q_valid = 1'b1; bus.q_time = 16'h0080;
        tick();
        pulse(0, 16'h0077, 3'd4);
        tick();
        bus.core_new_valid = '0;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.core_event_valid !== 4'b0100) begin errors++; $display("FAIL burst_setup: got v%b cev %b exp v1 0100", bus.out_valid, bus.core_event_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_time !== 16'h0 || bus.out_id !== 3'd0) begin errors++; $display("FAIL async_out: got v%b %h/%0d exp v0 0000/0", bus.out_valid, bus.out_time, bus.out_id); end
        checks++; if (bus.core_event_valid !== 4'b0 || bus.core_event_time !== 16'h0 || bus.core_random !== 8'h0) begin errors++; $display("FAIL async_core: got %b %h %h exp 0000 0000 00", bus.core_event_valid, bus.core_event_time, bus.core_random); end
        checks++; if (bus.global_time !== 16'h0 || bus.q_pop !== 1'b0) begin errors++; $display("FAIL async_gvt_pop: got %h %b exp 0000 0", bus.global_time, bus.q_pop); end
        tick();
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic             m_busy[NCORE], m_pend[NCORE], m_ov;
        logic [15:0]      m_dtime[NCORE], m_ht[NCORE], m_ot, m_gvt, m_lfsr, m_cet, qt;
        logic [NIDB-1:0]  m_hid[NCORE], m_oid, m_ceid, qi;
        logic [NCORE-1:0] m_cev, cnv;
        logic [NRB-1:0]   m_crand;
        logic [15:0]      cnt[NCORE];
        logic [NIDB-1:0]  cnid[NCORE];
        logic             qv, ordy, pop, acc, cap[NCORE];
        int               m_rr, m_owner, k, gj;
        int               terms[$], mins[$];
        do_reset();
        for (int i = 0; i < NCORE; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_dtime[i] = 0; m_ht[i] = 0; m_hid[i] = 0;
        end
        m_ov = 0; m_ot = 0; m_oid = 0; m_gvt = 0; m_lfsr = SEED; m_cet = 0; m_ceid = 0;
        m_cev = 0; m_crand = 0; m_rr = 0; m_owner = 0; qt = 16'h0100;
        for (int cyc = 0; cyc < 400; cyc++) begin
            qv = ($urandom_range(0, 3) != 0);
            qt = qt + 16'($urandom_range(0, 3));
            qi = NIDB'($urandom);
            ordy = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < NCORE; c++) begin
                cnv[c] = ($urandom_range(0, 3) == 0);
                cnt[c] = qt + 16'($urandom_range(1, 50));
                cnid[c] = NIDB'($urandom);
                bus.core_new_time[16*c +: 16] = cnt[c];
                bus.core_new_target[NIDB*c +: NIDB] = cnid[c];
            end
            bus.q_valid = qv; bus.q_time = qt; bus.q_id = qi;
            bus.core_new_valid = cnv; bus.out_ready = ordy;
            #1;
            k = -1;
            for (int i = NCORE - 1; i >= 0; i--) if (!m_busy[i]) k = i;
            pop = qv && (k >= 0);
            checks++; if (bus.q_pop !== pop) begin errors++; $display("FAIL rnd_q_pop@%0d: got %b exp %b", cyc, bus.q_pop, pop); end
            checks++; if (bus.out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid@%0d: got %b exp %b", cyc, bus.out_valid, m_ov); end
            if (m_ov) begin
                checks++; if (bus.out_time !== m_ot || bus.out_id !== m_oid) begin errors++; $display("FAIL rnd_out_data@%0d: got %h/%0d exp %h/%0d", cyc, bus.out_time, bus.out_id, m_ot, m_oid); end
            end
            checks++; if (bus.core_event_valid !== m_cev) begin errors++; $display("FAIL rnd_cev@%0d: got %b exp %b", cyc, bus.core_event_valid, m_cev); end
            if (m_cev != 0) begin
                checks++; if (bus.core_random !== m_crand || bus.core_event_time !== m_cet || bus.core_event_id !== m_ceid) begin errors++; $display("FAIL rnd_dispatch@%0d: got %h %h %0d exp %h %h %0d", cyc, bus.core_random, bus.core_event_time, bus.core_event_id, m_crand, m_cet, m_ceid); end
            end
            checks++; if (bus.global_time !== m_gvt) begin errors++; $display("FAIL rnd_gvt@%0d: got %h exp %h", cyc, bus.global_time, m_gvt); end
            // next state, all decisions taken from the pre-edge model state
            terms = {};
            if (qv) terms.push_back(int'(qt));
            for (int i = 0; i < NCORE; i++) if (m_busy[i]) terms.push_back(int'(m_dtime[i]));
            if (terms.size() > 0) begin mins = terms.min(); m_gvt = 16'(mins[0]); end
            for (int i = 0; i < NCORE; i++) cap[i] = cnv[i] && m_busy[i] && !m_pend[i];
            acc = m_ov && ordy;
            gj = -1;
            for (int o = 0; o < NCORE; o++) if (gj < 0 && m_pend[(m_rr + o) % NCORE]) gj = (m_rr + o) % NCORE;
            if (acc) m_busy[m_owner] = 0;
            if ((!m_ov || ordy) && gj >= 0) begin
                m_ov = 1; m_ot = m_ht[gj]; m_oid = m_hid[gj]; m_owner = gj;
                m_rr = (gj + 1) % NCORE; m_pend[gj] = 0;
            end else if (acc) begin
                m_ov = 0;
            end
            for (int i = 0; i < NCORE; i++) if (cap[i]) begin m_pend[i] = 1; m_ht[i] = cnt[i]; m_hid[i] = cnid[i]; end
            m_cev = '0;
            if (pop) begin
                m_cev[k] = 1'b1; m_busy[k] = 1; m_dtime[k] = qt;
                m_cet = qt; m_ceid = qi; m_crand = m_lfsr[NRB-1:0]; m_lfsr = lfsr_step(m_lfsr);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_collect_release();
        test_round_robin();
        test_gvt();
        test_spurious_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
